// File: rtl/s2p_stream_arbiter.sv
// Round-robin arbiter that grants one serial requester at a time and packs its bits LSB-first
// into P_WIDTH-bit words. Define S2P_ARB_ERR_CNT_EN to enable the saturating abort counter.
module s2p_stream_arbiter #(
    parameter int unsigned P_WIDTH     = 2,
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned BURST_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_bit,
    input  logic [NUM_REQ-1:0] req_bvalid,
    output logic [NUM_REQ-1:0] gnt,
    output logic [P_WIDTH-1:0] par_data,
    output logic               par_valid,
    output logic [2:0]         par_id,
    output logic               abort,
    output logic [7:0]         err_cnt
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned BcW  = $clog2(P_WIDTH);
    localparam int unsigned WcW  = $clog2(BURST_WORDS + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [BcW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WcW-1:0]      word_cnt_q, word_cnt_d;
    logic [P_WIDTH-1:0]  shift_q, shift_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [P_WIDTH-1:0]  par_data_q, par_data_d;
    logic                par_valid_q, par_valid_d;
    logic [2:0]          par_id_q, par_id_d;
    logic                abort_q, abort_d;
    logic [IdxW-1:0]     pick, cand;
    logic [P_WIDTH-1:0]  word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            last_q      <= IdxW'(NUM_REQ - 1);
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            gnt_q       <= '0;
            par_data_q  <= '0;
            par_valid_q <= 1'b0;
            par_id_q    <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            gnt_q       <= gnt_d;
            par_data_q  <= par_data_d;
            par_valid_q <= par_valid_d;
            par_id_q    <= par_id_d;
            abort_q     <= abort_d;
        end
    end

    // Scan downwards so the nearest requester after last_owner is the final (winning) write.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand = IdxW'((int'(last_q) + k) % int'(NUM_REQ));
            if (req[cand]) pick = cand;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        gnt_d       = gnt_q;
        par_data_d  = par_data_q;
        par_valid_d = 1'b0;
        par_id_d    = par_id_q;
        abort_d     = 1'b0;
        word        = shift_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d    = StBusy;
                    owner_d    = pick;
                    gnt_d      = NUM_REQ'(1) << pick;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            StBusy: begin
                if (!req[owner_q]) begin
                    // A bit strobed in the same cycle as the drop is deliberately ignored.
                    abort_d    = (bit_cnt_q != '0);
                    state_d    = StIdle;
                    gnt_d      = '0;
                    last_d     = owner_q;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end else if (req_bvalid[owner_q]) begin
                    word[bit_cnt_q] = req_bit[owner_q];
                    shift_d         = word;
                    if (bit_cnt_q == BcW'(P_WIDTH - 1)) begin
                        bit_cnt_d   = '0;
                        par_valid_d = 1'b1;
                        par_data_d  = word;
                        par_id_d    = 3'(owner_q);
                        if (word_cnt_q == WcW'(BURST_WORDS - 1)) begin
                            state_d    = StIdle;
                            gnt_d      = '0;
                            last_d     = owner_q;
                            word_cnt_d = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        par_data  = par_data_q;
        par_valid = par_valid_q;
        par_id    = par_id_q;
        abort     = abort_q;
    end

`ifdef S2P_ARB_ERR_CNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (abort_d && (err_q != 8'hff)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_s2p_stream_arbiter.sv
// Directed bench for s2p_stream_arbiter: a vector table for a single burst, then hand-written
// sequences for alternation, aborts, reset mid-word and err_cnt saturation.
module tb_s2p_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, req_bit, req_bvalid;
    logic [1:0] gnt;
    logic [1:0] par_data;
    logic       par_valid;
    logic [2:0] par_id;
    logic       abort;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    s2p_stream_arbiter #(
        .P_WIDTH    (2),
        .NUM_REQ    (2),
        .BURST_WORDS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_bit   (req_bit),
        .req_bvalid(req_bvalid),
        .gnt       (gnt),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_id    (par_id),
        .abort     (abort),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] bits;
        logic [1:0] bv;
        logic [1:0] gnt;
        logic       pv;
        logic [1:0] pd;
        logic [2:0] pid;
        logic       ab;
    } vec_t;

    vec_t tbl [11];

`ifdef S2P_ARB_ERR_CNT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one edge, land 1 time unit after it for sampling.
    task automatic tick(input logic [1:0] r, input logic [1:0] b, input logic [1:0] v);
        req        = r;
        req_bit    = b;
        req_bvalid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2'b00, 2'b00, 2'b00);
        rst = 1'b0;
    endtask

    initial begin
        int pulses [3];
        int total;
        logic [1:0] exp_gnt;
        int blk;

        rst = 1'b0;
        // req, bits, bvalid | gnt, pv, pd, pid, abort
        tbl[0]  = '{2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 3'd0, 1'b0};
        tbl[1]  = '{2'b01, 2'b01, 2'b11, 2'b01, 1'b0, 2'b00, 3'd0, 1'b0};
        tbl[2]  = '{2'b01, 2'b10, 2'b11, 2'b01, 1'b1, 2'b01, 3'd0, 1'b0};
        tbl[3]  = '{2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 2'b01, 3'd0, 1'b0};
        tbl[4]  = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 3'd0, 1'b0};
        tbl[5]  = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 2'b11, 3'd0, 1'b0};
        tbl[6]  = '{2'b01, 2'b10, 2'b11, 2'b01, 1'b0, 2'b11, 3'd0, 1'b0};
        tbl[7]  = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 2'b10, 3'd0, 1'b0};
        tbl[8]  = '{2'b01, 2'b11, 2'b11, 2'b01, 1'b0, 2'b10, 3'd0, 1'b0};
        tbl[9]  = '{2'b01, 2'b10, 2'b01, 2'b00, 1'b1, 2'b01, 3'd0, 1'b0};
        tbl[10] = '{2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01, 3'd0, 1'b0};

        do_reset();
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset par_valid", 32'(par_valid), 32'd0);
        chk("reset par_data", 32'(par_data), 32'd0);
        chk("reset par_id", 32'(par_id), 32'd0);
        chk("reset abort", 32'(abort), 32'd0);
        chk("reset err_cnt", 32'(err_cnt), 32'd0);

        // Single burst from requester 0 with requester 1 strobing noise.
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].req, tbl[i].bits, tbl[i].bv);
            chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d par_valid", i), 32'(par_valid), 32'(tbl[i].pv));
            chk($sformatf("vec%0d par_data", i), 32'(par_data), 32'(tbl[i].pd));
            chk($sformatf("vec%0d par_id", i), 32'(par_id), 32'(tbl[i].pid));
            chk($sformatf("vec%0d abort", i), 32'(abort), 32'(tbl[i].ab));
        end

        // Both requesting continuously: 8 busy cycles then one idle cycle per grant.
        do_reset();
        pulses = '{0, 0, 0};
        total  = 0;
        for (int n = 1; n <= 27; n++) begin
            tick(2'b11, 2'b11, 2'b11);
            blk     = (n - 1) / 9;
            exp_gnt = ((n - 1) % 9 == 8) ? 2'b00 : ((blk % 2 == 1) ? 2'b10 : 2'b01);
            chk($sformatf("alt gnt n=%0d", n), 32'(gnt), 32'(exp_gnt));
            if (par_valid) begin
                pulses[blk]++;
                total++;
                chk($sformatf("alt par_id n=%0d", n), 32'(par_id), 32'(blk % 2));
                chk($sformatf("alt par_data n=%0d", n), 32'(par_data), 32'd3);
            end
        end
        for (int g = 0; g < 3; g++) chk($sformatf("alt words grant%0d", g), 32'(pulses[g]), 32'd4);
        chk("alt total words", 32'(total), 32'd12);

        // Owner drops after one bit (with a bit strobed on the drop cycle) -> abort.
        do_reset();
        tick(2'b01, 2'b00, 2'b00);
        chk("abort grant", 32'(gnt), 32'd1);
        tick(2'b01, 2'b01, 2'b01);
        chk("abort mid par_valid", 32'(par_valid), 32'd0);
        tick(2'b00, 2'b01, 2'b01);
        chk("abort pulse", 32'(abort), 32'd1);
        chk("abort gnt", 32'(gnt), 32'd0);
        chk("abort par_valid", 32'(par_valid), 32'd0);
        tick(2'b00, 2'b00, 2'b00);
        chk("abort one-cycle", 32'(abort), 32'd0);
        chk("abort err_cnt", 32'(err_cnt), ErrEn ? 32'd1 : 32'd0);

        // Drop at a word boundary ends the grant quietly.
        tick(2'b01, 2'b00, 2'b00);
        chk("clean drop grant", 32'(gnt), 32'd1);
        tick(2'b00, 2'b00, 2'b00);
        chk("clean drop gnt", 32'(gnt), 32'd0);
        chk("clean drop abort", 32'(abort), 32'd0);
        tick(2'b00, 2'b00, 2'b00);
        chk("clean drop abort later", 32'(abort), 32'd0);

        // Reset mid-word, then the same requester streams 0,0.
        do_reset();
        tick(2'b01, 2'b00, 2'b00);
        tick(2'b01, 2'b01, 2'b01);
        rst = 1'b1;
        tick(2'b01, 2'b00, 2'b00);
        rst = 1'b0;
        chk("rst mid gnt", 32'(gnt), 32'd0);
        chk("rst mid abort", 32'(abort), 32'd0);
        tick(2'b01, 2'b00, 2'b00);
        chk("rst regrant", 32'(gnt), 32'd1);
        chk("rst regrant abort", 32'(abort), 32'd0);
        tick(2'b01, 2'b00, 2'b01);
        chk("rst first bit par_valid", 32'(par_valid), 32'd0);
        tick(2'b01, 2'b00, 2'b01);
        chk("rst word par_valid", 32'(par_valid), 32'd1);
        chk("rst word par_data", 32'(par_data), 32'd0);

        // 300 forced aborts.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick(2'b01, 2'b00, 2'b00);
            tick(2'b01, 2'b01, 2'b01);
            tick(2'b00, 2'b00, 2'b00);
            if (i == 9) chk("err_cnt after 10", 32'(err_cnt), ErrEn ? 32'd10 : 32'd0);
        end
        tick(2'b00, 2'b00, 2'b00);
        chk("err_cnt saturated", 32'(err_cnt), ErrEn ? 32'd255 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
